// File: rtl/nrisc_boot_loader_if.sv
// nrisc_boot_loader_if: byte-stream input and instruction-memory write port of the boot loader
interface nrisc_boot_loader_if #(parameter int ADDR_W = 8);
  logic rx_valid;
  logic rx_ready;
  logic [7:0] rx_data;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0] imem_wdata;
  modport master(output rx_valid, rx_data, input rx_ready, imem_we, imem_addr, imem_wdata);
  modport slave(input rx_valid, rx_data, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/nrisc_boot_loader.sv
// nrisc_boot_loader: loads a framed, checksummed program image into imem and releases the nRisc core
module nrisc_boot_loader #(
  parameter int ADDR_W = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT = 1000
) (
  input  logic CLK,
  input  logic reset,
  nrisc_boot_loader_if.slave bus,
  output logic core_reset,
  output logic done,
  output logic error
);
  typedef enum logic [2:0] {IDLE, LEN, LOAD, CHECK, RUN, ERR} state_t;
  state_t state;
  logic [7:0] count;
  logic [7:0] sum;
  logic [ADDR_W-1:0] addr;
  logic [15:0] timer;
  logic acc;
  assign acc = bus.rx_valid && bus.rx_ready;
  always_ff @(posedge CLK)
    if (reset) begin
      state <= IDLE;
      bus.rx_ready <= 1'b0;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= 8'd0;
      core_reset <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      count <= 8'd0;
      sum <= 8'd0;
      addr <= '0;
      timer <= 16'd0;
    end else begin
      bus.imem_we <= 1'b0;
      bus.rx_ready <= !(state inside {RUN, ERR});
      timer <= (acc || !(state inside {LEN, LOAD, CHECK})) ? 16'd0 : timer + 16'd1;
      case (state)
        IDLE: if (acc && bus.rx_data == SYNC_BYTE) state <= LEN;
        LEN: if (acc) begin
          if (bus.rx_data == 8'd0 || int'(bus.rx_data) > (1 << ADDR_W)) begin
            state <= ERR;
            bus.rx_ready <= 1'b0;
            error <= 1'b1;
          end else begin
            count <= bus.rx_data;
            addr <= '0;
            sum <= 8'd0;
            state <= LOAD;
          end
        end
        LOAD: if (acc) begin
          bus.imem_we <= 1'b1;
          bus.imem_addr <= addr;
          bus.imem_wdata <= bus.rx_data;
          sum <= sum + bus.rx_data;
          addr <= addr + ADDR_W'(1);
          count <= count - 8'd1;
          if (count == 8'd1) state <= CHECK;
        end
        CHECK: if (acc) begin
          state <= (bus.rx_data == sum) ? RUN : ERR;
          bus.rx_ready <= 1'b0;
          core_reset <= bus.rx_data != sum;
          done <= bus.rx_data == sum;
          error <= bus.rx_data != sum;
        end
        default: ;
      endcase
      // a stalled frame is abandoned rather than left waiting forever
      if (!acc && state inside {LEN, LOAD, CHECK} && timer == 16'(TIMEOUT - 1)) begin
        state <= ERR;
        bus.rx_ready <= 1'b0;
        error <= 1'b1;
      end
    end
endmodule

// File: tb/tb_nrisc_boot_loader.sv
// tb_nrisc_boot_loader: directed and random frames checked against a frame-parsing reference model
module tb_nrisc_boot_loader;
  localparam int ADDR_W = 8;
  localparam int TIMEOUT = 1000;
  localparam logic [7:0] SYNC = 8'hA5;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic core_reset, done, error;
  int checks = 0;
  int failures = 0;
  logic [7:0] stream[$];
  nrisc_boot_loader_if #(.ADDR_W(ADDR_W)) bus();
  nrisc_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset), .bus(bus), .core_reset(core_reset), .done(done), .error(error)
  );
  always #5 CLK = ~CLK;
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'd0;
    @(negedge CLK);
    check("rst_rx_ready", 32'(bus.rx_ready), 0);
    check("rst_imem_we", 32'(bus.imem_we), 0);
    check("rst_imem_addr", 32'(bus.imem_addr), 0);
    check("rst_imem_wdata", 32'(bus.imem_wdata), 0);
    check("rst_core_reset", 32'(core_reset), 1);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    reset = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", 32'(bus.rx_ready), 1);
  endtask
  // Model: locate the frame by position, then derive each byte's role and the verdict.
  task automatic run_stream(input int max_gap);
    int s, n, t, total, gap;
    bit len_ok, run_ok, pay;
    s = -1;
    foreach (stream[j]) if (s < 0 && stream[j] == SYNC) s = j;
    n = int'(stream[s + 1]);
    len_ok = n != 0 && n <= (1 << ADDR_W);
    t = len_ok ? s + 2 + n : s + 1;
    total = 0;
    if (len_ok) for (int j = s + 2; j < t; j++) total += int'(stream[j]);
    run_ok = len_ok && int'(stream[t]) == total % 256;
    for (int j = 0; j < stream.size(); j++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = stream[j];
      @(negedge CLK);
      pay = len_ok && j >= s + 2 && j < t;
      check("wr_strobe", 32'(bus.imem_we), 32'(pay));
      if (pay) begin
        check("wr_addr", 32'(bus.imem_addr), 32'(j - s - 2));
        check("wr_data", 32'(bus.imem_wdata), 32'(stream[j]));
      end
      bus.rx_valid = 1'b0;
      gap = (j < stream.size() - 1) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        @(negedge CLK);
        check("gap_no_write", 32'(bus.imem_we), 0);
      end
    end
    check("end_done", 32'(done), 32'(run_ok));
    check("end_error", 32'(error), 32'(!run_ok));
    check("end_core_reset", 32'(core_reset), 32'(!run_ok));
    check("end_rx_ready", 32'(bus.rx_ready), 0);
  endtask
  task automatic gen_random();
    int pre, n, kind;
    logic [7:0] b, s8;
    stream.delete();
    pre = $urandom_range(0, 3);
    kind = $urandom_range(0, 9);
    repeat (pre) begin
      b = 8'($urandom);
      stream.push_back(b == SYNC ? 8'h5A : b);
    end
    stream.push_back(SYNC);
    n = (kind == 0) ? 0 : $urandom_range(1, 12);
    stream.push_back(8'(n));
    s8 = 8'd0;
    repeat (n) begin
      b = 8'($urandom);
      s8 += b;
      stream.push_back(b);
    end
    if (n != 0) stream.push_back(kind == 1 ? s8 ^ 8'($urandom_range(1, 255)) : s8);
    repeat ($urandom_range(0, 2)) stream.push_back(8'($urandom));
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'd0;
    do_reset();
    stream = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h9C};
    run_stream(0);
    do_reset();
    stream = '{8'h00, 8'h7F, 8'hA5, 8'h01, 8'hFF, 8'hFF};
    run_stream(0);
    do_reset();
    stream = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    run_stream(0);
    do_reset();
    stream = '{8'hA5, 8'h00, 8'h11};
    run_stream(0);
    do_reset();
    foreach (stream[j]) stream.delete();
    stream = '{8'hA5, 8'h04, 8'h01};
    foreach (stream[j]) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = stream[j];
      @(negedge CLK);
    end
    bus.rx_valid = 1'b0;
    check("to_last_write", 32'(bus.imem_we), 1);
    repeat (TIMEOUT - 1) @(negedge CLK);
    check("to_not_yet", 32'(error), 0);
    @(negedge CLK);
    check("to_error", 32'(error), 1);
    check("to_rx_ready", 32'(bus.rx_ready), 0);
    check("to_core_reset", 32'(core_reset), 1);
    check("to_done", 32'(done), 0);
    do_reset();
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22};
    foreach (stream[j]) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = stream[j];
      @(negedge CLK);
    end
    check("mid_write", 32'(bus.imem_we), 1);
    do_reset();
    stream = '{8'hA5, 8'h01, 8'h42, 8'h42};
    run_stream(0);
    repeat (24) begin
      gen_random();
      do_reset();
      run_stream(3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
